// File: rtl/multicycle_controller_if.sv
// Control bundle between the multicycle controller and the RV32I datapath.
// The controller is the master: it reads the latched instruction fields and
// the ALU zero flag, and drives every datapath enable and mux select.
interface multicycle_controller_if;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       Zero;

  logic       PCWrite;
  logic       AdrSrc;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegWrite;
  logic [1:0] ResultSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [2:0] ImmSrc;
  logic [2:0] ALUControl;
  logic       Illegal;

  modport master (
    input  op, funct3, funct7b5, Zero,
    output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
           ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl, Illegal
  );

  modport slave (
    output op, funct3, funct7b5, Zero,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
           ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl, Illegal
  );
endinterface

// File: rtl/multicycle_controller.sv
// Main control FSM of the multicycle RV32I core.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// FETCH     | read instruction at PC, latch IR/OldPC, PC <= PC+4
// DECODE    | ALUOut <= OldPC+imm (branch/jump target), pick next path
// MEMADR    | ALUOut <= rs1+imm (load/store address)
// MEMREAD   | memory read at ALUOut
// MEMWB     | rd <= loaded data
// MEMWRITE  | memory write at ALUOut
// EXECR     | ALUOut <= rs1 op rs2
// EXECI     | ALUOut <= rs1 op imm
// ALUWB     | rd <= ALUOut
// BRANCH    | compare rs1-rs2, PC <= ALUOut when taken
// JAL       | PC <= ALUOut (target), ALUOut <= OldPC+4 for the link
// TRAP      | unsupported instruction; frozen until reset
module multicycle_controller (
  input  logic clk,
  input  logic rst_n,
  multicycle_controller_if.master bus
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECR, S_EXECI, S_ALUWB, S_BRANCH, S_JAL, S_TRAP
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLL = 3'b101;
  localparam logic [2:0] ALU_SRL = 3'b110;
  localparam logic [2:0] ALU_SRA = 3'b111;

  state_t     state, state_next;

  logic       alu_funct_ok;
  logic       branch_funct_ok;
  logic       taken;
  logic [2:0] alu_decoded;

  logic       pc_update;
  logic       branch_en;
  logic       adr_src;
  logic       mem_write;
  logic       ir_write;
  logic       reg_write;
  logic [1:0] result_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] alu_control;
  logic [2:0] imm_src;

  // State register; reset parks the FSM in FETCH, which also clears Illegal.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_FETCH;
    else        state <= state_next;
  end

  // Which function codes the ALU path and the branch unit can execute.
  // slt/sltu have no ALU encoding; only beq/bne are implemented.
  always_comb begin
    alu_funct_ok    = (bus.funct3 != 3'b010) && (bus.funct3 != 3'b011);
    branch_funct_ok = (bus.funct3 == 3'b000) || (bus.funct3 == 3'b001);
  end

  // ALU operation for EXECR/EXECI. Only R-type may select sub, so addi with
  // a negative immediate (bit 30 set) still adds.
  always_comb begin
    alu_decoded = ALU_ADD;
    unique case (bus.funct3)
      3'b000:  alu_decoded = ((bus.op == OP_RTYPE) && bus.funct7b5) ? ALU_SUB : ALU_ADD;
      3'b001:  alu_decoded = ALU_SLL;
      3'b100:  alu_decoded = ALU_XOR;
      3'b101:  alu_decoded = bus.funct7b5 ? ALU_SRA : ALU_SRL;
      3'b110:  alu_decoded = ALU_OR;
      3'b111:  alu_decoded = ALU_AND;
      default: alu_decoded = ALU_ADD;
    endcase
  end

  // Branch condition, evaluated on the live Zero flag while in BRANCH.
  always_comb begin
    taken = 1'b0;
    if (bus.funct3 == 3'b000)      taken = bus.Zero;
    else if (bus.funct3 == 3'b001) taken = !bus.Zero;
  end

  // Immediate format follows the opcode in every state.
  always_comb begin
    imm_src = 3'b000;
    unique case (bus.op)
      OP_STORE:  imm_src = 3'b001;
      OP_BRANCH: imm_src = 3'b010;
      OP_JAL:    imm_src = 3'b011;
      default:   imm_src = 3'b000;
    endcase
  end

  // Next-state and Moore outputs per state; everything not set stays 0.
  always_comb begin
    state_next  = state;
    pc_update   = 1'b0;
    branch_en   = 1'b0;
    adr_src     = 1'b0;
    mem_write   = 1'b0;
    ir_write    = 1'b0;
    reg_write   = 1'b0;
    result_src  = 2'b00;
    alu_src_a   = 2'b00;
    alu_src_b   = 2'b00;
    alu_control = ALU_ADD;

    unique case (state)
      S_FETCH: begin
        ir_write   = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        pc_update  = 1'b1;
        state_next = S_DECODE;
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        unique case (bus.op)
          OP_LOAD, OP_STORE: state_next = S_MEMADR;
          OP_RTYPE:          state_next = alu_funct_ok ? S_EXECR : S_TRAP;
          OP_ITYPE:          state_next = alu_funct_ok ? S_EXECI : S_TRAP;
          OP_BRANCH:         state_next = branch_funct_ok ? S_BRANCH : S_TRAP;
          OP_JAL:            state_next = S_JAL;
          default:           state_next = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        alu_src_a  = 2'b10;
        alu_src_b  = 2'b01;
        state_next = (bus.op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        adr_src    = 1'b1;
        state_next = S_MEMWB;
      end
      S_MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
        state_next = S_FETCH;
      end
      S_MEMWRITE: begin
        adr_src    = 1'b1;
        mem_write  = 1'b1;
        state_next = S_FETCH;
      end
      S_EXECR: begin
        alu_src_a   = 2'b10;
        alu_control = alu_decoded;
        state_next  = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a   = 2'b10;
        alu_src_b   = 2'b01;
        alu_control = alu_decoded;
        state_next  = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write  = 1'b1;
        state_next = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a   = 2'b10;
        alu_control = ALU_SUB;
        branch_en   = 1'b1;
        state_next  = S_FETCH;
      end
      S_JAL: begin
        alu_src_a  = 2'b01;
        alu_src_b  = 2'b10;
        pc_update  = 1'b1;
        state_next = S_ALUWB;
      end
      S_TRAP: begin
        state_next = S_TRAP;
      end
      default: begin
        state_next = S_FETCH;
      end
    endcase
  end

  // Write enables are gated by rst_n so nothing writes while reset is held,
  // even though the parked FETCH state would otherwise request a fetch.
  always_comb begin
    bus.PCWrite    = rst_n & (pc_update | (branch_en & taken));
    bus.IRWrite    = rst_n & ir_write;
    bus.MemWrite   = rst_n & mem_write;
    bus.RegWrite   = rst_n & reg_write;
    bus.AdrSrc     = adr_src;
    bus.ResultSrc  = result_src;
    bus.ALUSrcA    = alu_src_a;
    bus.ALUSrcB    = alu_src_b;
    bus.ALUControl = alu_control;
    bus.ImmSrc     = imm_src;
    bus.Illegal    = (state == S_TRAP);
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: a table of legal instructions
// checked for cycle count, enable counts and decode, plus hand sequences for
// reset, lw/jal per-cycle outputs, traps and mid-instruction reset.
module tb_multicycle_controller;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  multicycle_controller_if bus ();

  multicycle_controller dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [31:0] instr;
    logic        zero;
    int          cycles;
    int          pcw;
    int          rw;
    int          mw;
    logic [2:0]  alu;
    logic [2:0]  imm;
  } vec_t;

  vec_t vecs[19];

  // {PCWrite,AdrSrc,MemWrite,IRWrite,RegWrite,ResultSrc,ALUSrcA,ALUSrcB,ALUControl}
  localparam logic [14:0] SIG_FETCH   = {5'b10010, 2'b10, 2'b00, 2'b10, 3'b000};
  localparam logic [14:0] SIG_DECODE  = {5'b00000, 2'b00, 2'b01, 2'b01, 3'b000};
  localparam logic [14:0] SIG_MEMADR  = {5'b00000, 2'b00, 2'b10, 2'b01, 3'b000};
  localparam logic [14:0] SIG_MEMREAD = {5'b01000, 2'b00, 2'b00, 2'b00, 3'b000};
  localparam logic [14:0] SIG_MEMWB   = {5'b00001, 2'b01, 2'b00, 2'b00, 3'b000};
  localparam logic [14:0] SIG_JAL     = {5'b10000, 2'b00, 2'b01, 2'b10, 3'b000};
  localparam logic [14:0] SIG_ALUWB   = {5'b00001, 2'b00, 2'b00, 2'b00, 3'b000};
  localparam logic [14:0] SIG_RESET   = {5'b00000, 2'b10, 2'b00, 2'b10, 3'b000};

  function automatic logic [14:0] sig();
    return {bus.PCWrite, bus.AdrSrc, bus.MemWrite, bus.IRWrite, bus.RegWrite,
            bus.ResultSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ALUControl};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic apply(input logic [31:0] instr);
    bus.op       = instr[6:0];
    bus.funct3   = instr[14:12];
    bus.funct7b5 = instr[30];
  endtask

  // Entered at negedge+1 with the DUT in FETCH; returns the same way.
  task automatic run_vec(input vec_t v, input int idx);
    int cyc = 0;
    int pcw = 0;
    int rw  = 0;
    int mw  = 0;
    int ill = 0;
    logic [2:0] alu_x = 3'b000;
    logic [2:0] imm_x;
    apply(v.instr);
    bus.Zero = v.zero;
    #1;
    imm_x = bus.ImmSrc;
    do begin
      pcw += int'(bus.PCWrite);
      rw  += int'(bus.RegWrite);
      mw  += int'(bus.MemWrite);
      ill += int'(bus.Illegal);
      if (cyc == 2) alu_x = bus.ALUControl;
      cyc++;
      @(negedge clk); #1;
    end while (!bus.IRWrite && cyc < 20);
    chk($sformatf("v%0d cycles", idx), cyc, v.cycles);
    chk($sformatf("v%0d pcwrite_count", idx), pcw, v.pcw);
    chk($sformatf("v%0d regwrite_count", idx), rw, v.rw);
    chk($sformatf("v%0d memwrite_count", idx), mw, v.mw);
    chk($sformatf("v%0d alucontrol", idx), {29'd0, alu_x}, {29'd0, v.alu});
    chk($sformatf("v%0d immsrc", idx), {29'd0, imm_x}, {29'd0, v.imm});
    chk($sformatf("v%0d illegal_cycles", idx), ill, 0);
  endtask

  // Reset from any state, then release; ends at negedge+1 in FETCH.
  task automatic reset_and_release(input string name);
    rst_n = 1'b0;
    #1;
    chk({name, " rst illegal"}, {31'd0, bus.Illegal}, 0);
    chk({name, " rst sig"}, {17'd0, sig()}, {17'd0, SIG_RESET});
    @(posedge clk);
    @(negedge clk);
    #1;
    chk({name, " rst held sig"}, {17'd0, sig()}, {17'd0, SIG_RESET});
    rst_n = 1'b1;
    #1;
    chk({name, " release fetch"}, {30'd0, bus.IRWrite, bus.PCWrite}, 2'b11);
  endtask

  task automatic trap_seq(input logic [31:0] instr, input string name);
    int bad = 0;
    apply(instr);
    bus.Zero = 1'b0;
    #1;
    chk({name, " fetch"}, {17'd0, sig()}, {17'd0, SIG_FETCH});
    @(negedge clk); #1;
    chk({name, " decode"}, {16'd0, bus.Illegal, sig()}, {16'd0, 1'b0, SIG_DECODE});
    for (int c = 0; c < 12; c++) begin
      @(negedge clk); #1;
      if (bus.Illegal !== 1'b1 || sig() !== 15'd0) bad++;
    end
    chk({name, " trap hold bad cycles"}, bad, 0);
    reset_and_release(name);
  endtask

  initial begin
    vecs[0]  = '{32'h002081B3, 1'b0, 4, 1, 1, 0, 3'b000, 3'b000}; // add
    vecs[1]  = '{32'h402081B3, 1'b0, 4, 1, 1, 0, 3'b001, 3'b000}; // sub
    vecs[2]  = '{32'h4020D1B3, 1'b0, 4, 1, 1, 0, 3'b111, 3'b000}; // sra
    vecs[3]  = '{32'h0020D1B3, 1'b0, 4, 1, 1, 0, 3'b110, 3'b000}; // srl
    vecs[4]  = '{32'h0020C1B3, 1'b0, 4, 1, 1, 0, 3'b100, 3'b000}; // xor
    vecs[5]  = '{32'h0020E1B3, 1'b0, 4, 1, 1, 0, 3'b011, 3'b000}; // or
    vecs[6]  = '{32'h0020F1B3, 1'b0, 4, 1, 1, 0, 3'b010, 3'b000}; // and
    vecs[7]  = '{32'h002091B3, 1'b0, 4, 1, 1, 0, 3'b101, 3'b000}; // sll
    vecs[8]  = '{32'h00508193, 1'b0, 4, 1, 1, 0, 3'b000, 3'b000}; // addi
    vecs[9]  = '{32'h40008193, 1'b0, 4, 1, 1, 0, 3'b000, 3'b000}; // addi, bit30 set
    vecs[10] = '{32'h4050D193, 1'b0, 4, 1, 1, 0, 3'b111, 3'b000}; // srai
    vecs[11] = '{32'h0050C193, 1'b0, 4, 1, 1, 0, 3'b100, 3'b000}; // xori
    vecs[12] = '{32'h0000A183, 1'b0, 5, 1, 1, 0, 3'b000, 3'b000}; // lw
    vecs[13] = '{32'h0020A023, 1'b0, 4, 1, 0, 1, 3'b000, 3'b001}; // sw
    vecs[14] = '{32'h00000063, 1'b1, 3, 2, 0, 0, 3'b001, 3'b010}; // beq taken
    vecs[15] = '{32'h00000063, 1'b0, 3, 1, 0, 0, 3'b001, 3'b010}; // beq not taken
    vecs[16] = '{32'h00001063, 1'b0, 3, 2, 0, 0, 3'b001, 3'b010}; // bne taken
    vecs[17] = '{32'h00001063, 1'b1, 3, 1, 0, 0, 3'b001, 3'b010}; // bne not taken
    vecs[18] = '{32'h0000006F, 1'b0, 4, 2, 1, 0, 3'b000, 3'b011}; // jal

    // Reset held for 3 cycles with an R-type opcode presented.
    apply(32'h002081B3);
    bus.Zero = 1'b0;
    rst_n = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      chk($sformatf("reset c%0d sig", c), {17'd0, sig()}, {17'd0, SIG_RESET});
      chk($sformatf("reset c%0d illegal", c), {31'd0, bus.Illegal}, 0);
    end
    rst_n = 1'b1;
    #1;
    chk("first fetch enables", {30'd0, bus.IRWrite, bus.PCWrite}, 2'b11);

    for (int i = 0; i < 19; i++) run_vec(vecs[i], i);

    // lw, output by output per cycle.
    begin
      logic [14:0] exp_lw [6];
      exp_lw = '{SIG_FETCH, SIG_DECODE, SIG_MEMADR, SIG_MEMREAD, SIG_MEMWB, SIG_FETCH};
      apply(32'h0000A183);
      #1;
      for (int c = 0; c < 6; c++) begin
        chk($sformatf("lw c%0d sig", c), {17'd0, sig()}, {17'd0, exp_lw[c]});
        if (c < 5) begin
          @(negedge clk); #1;
        end
      end
    end

    // jal, output by output per cycle.
    begin
      logic [14:0] exp_jal [5];
      exp_jal = '{SIG_FETCH, SIG_DECODE, SIG_JAL, SIG_ALUWB, SIG_FETCH};
      apply(32'h0000006F);
      #1;
      for (int c = 0; c < 5; c++) begin
        chk($sformatf("jal c%0d sig", c), {17'd0, sig()}, {17'd0, exp_jal[c]});
        if (c < 4) begin
          @(negedge clk); #1;
        end
      end
    end

    // Reset while in EXECR: the pending ALUWB write must never happen.
    apply(32'h002081B3);
    #1;
    @(negedge clk); #1;
    @(negedge clk); #1;
    chk("midreset execr sig", {17'd0, sig()}, {17'd0, {5'b00000, 2'b00, 2'b10, 2'b00, 3'b000}});
    reset_and_release("midreset");
    run_vec(vecs[0], 100);

    trap_seq(32'h0020A1B3, "slt");
    trap_seq(32'h0000007F, "op7f");
    trap_seq(32'h00002063, "br_f3_010");
    trap_seq(32'h0000B193, "sltiu");
    run_vec(vecs[13], 101);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
